// File: rtl/msg_tx_scheduler_pkg.sv
// Shared types and constants for the message transmit scheduler.
package msg_tx_scheduler_pkg;

  localparam int MSG_W                 = 5;
  localparam int DEFAULT_NREQ          = 4;
  localparam int DEFAULT_START_TIMEOUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LAUNCH     = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_COOLDOWN   = 3'd4
  } state_e;

endpackage

// File: rtl/msg_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant
// and wraps, so a requester is not re-granted before the others get a turn.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic found_s;

  // first active requester after last_grant, in wrap-around order
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      int            cand;
      logic [IW-1:0] idx_v;
      cand = int'(last_grant) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end else begin
        cand = cand;
      end
      idx_v = IW'(cand);
      if (!found_s && req[idx_v]) begin
        grant[idx_v] = 1'b1;
        grant_idx    = idx_v;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Round-robin scheduler that captures one requester's payload at a time and
// hands it to a serial transmitter, tracking start timeout and completion.
module msg_tx_scheduler
  import msg_tx_scheduler_pkg::*;
#(
  parameter int NREQ          = DEFAULT_NREQ,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MSG_W-1:0] req_msg,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  tx_send,
  output logic [MSG_W-1:0]      tx_msg,
  input  logic                  tx_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (START_TIMEOUT < 1) ? 1 : $clog2(START_TIMEOUT + 1);

  state_e            state_r, state_s;
  logic [IW-1:0]     last_grant_r, last_grant_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [NREQ-1:0]   grant_s;
  logic [IW-1:0]     grant_idx_s;
  logic              grant_ok_s, timeout_s;

  logic [NREQ-1:0]   ack_r, ack_s, done_r, done_s;
  logic              send_r, send_s, busy_r, busy_s, err_r, err_s;
  logic [MSG_W-1:0]  msg_r, msg_s;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req        (req),
    .last_grant (last_grant_r),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // a foreign or stale frame on the line blocks any new grant
  assign grant_ok_s = (|req) && !tx_valid;
  assign timeout_s  = (cnt_r == CW'(START_TIMEOUT));

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= IW'(NREQ - 1);
      cnt_r        <= '0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_ok_s) state_s = ST_LAUNCH;
        else            state_s = ST_IDLE;
      end
      ST_LAUNCH:     state_s = ST_WAIT_START;
      ST_WAIT_START: begin
        if (tx_valid)       state_s = ST_WAIT_DONE;
        else if (timeout_s) state_s = ST_IDLE;
        else                state_s = ST_WAIT_START;
      end
      ST_WAIT_DONE: begin
        if (!tx_valid) state_s = ST_COOLDOWN;
        else           state_s = ST_WAIT_DONE;
      end
      ST_COOLDOWN:   state_s = ST_IDLE;
      default:       state_s = ST_IDLE;
    endcase
  end

  // next values of the registered outputs and datapath
  always_comb begin
    ack_s        = '0;
    done_s       = '0;
    send_s       = 1'b0;
    err_s        = 1'b0;
    msg_s        = msg_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    busy_s       = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (grant_ok_s) begin
          ack_s        = grant_s;
          msg_s        = req_msg[grant_idx_s*MSG_W +: MSG_W];
          last_grant_s = grant_idx_s;
        end else begin
          ack_s = '0;
        end
      end
      ST_LAUNCH: begin
        send_s = 1'b1;
        cnt_s  = '0;
      end
      ST_WAIT_START: begin
        if (tx_valid) begin
          cnt_s = cnt_r;
        end else if (timeout_s) begin
          err_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_valid) done_s = {{(NREQ-1){1'b0}}, 1'b1} << last_grant_r;
        else           done_s = '0;
      end
      ST_COOLDOWN: begin
        done_s = '0;
      end
      default: begin
        done_s = '0;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r  <= '0;
      done_r <= '0;
      send_r <= 1'b0;
      busy_r <= 1'b0;
      err_r  <= 1'b0;
      msg_r  <= '0;
    end else begin
      ack_r  <= ack_s;
      done_r <= done_s;
      send_r <= send_s;
      busy_r <= busy_s;
      err_r  <= err_s;
      msg_r  <= msg_s;
    end
  end

  assign ack     = ack_r;
  assign done    = done_r;
  assign tx_send = send_r;
  assign busy    = busy_r;
  assign err     = err_r;
  assign tx_msg  = msg_r;

endmodule

// File: doc/msg_tx_scheduler.md
MSG_TX_SCHEDULER -- requirements
Module: msg_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters and SHALL be in the range 2..8.
REQ-002 Parameter START_TIMEOUT, default 4, is the maximum number of clocks from the tx_send pulse to tx_valid rising.
REQ-003 Port clk, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, width 1: asynchronous, active-low reset.
REQ-005 Port req, input, width NREQ: per-requester send request, level, held until that requester's ack.
REQ-006 Port req_msg, input, width NREQ*5: 5-bit payload per requester; slice i is bits [5i+4:5i].
REQ-007 Port ack, output, width NREQ: one-hot, one-cycle pulse when a requester's payload is captured.
REQ-008 Port done, output, width NREQ: one-hot, one-cycle pulse when that requester's message finishes transmission.
REQ-009 Port tx_send, output, width 1: one-cycle start pulse to the serial message transmitter.
REQ-010 Port tx_msg, output, width 5: captured payload, held stable from the capture cycle until the scheduler returns to IDLE.
REQ-011 Port tx_valid, input, width 1: transmitter busy/valid level, high for the whole frame.
REQ-012 Port busy, output, width 1: high in every state except IDLE.
REQ-013 Port err, output, width 1: one-cycle pulse on start timeout.

Function
REQ-014 The FSM SHALL have the states IDLE, LAUNCH, WAIT_START, WAIT_DONE and COOLDOWN.
REQ-015 IDLE: if req is nonzero and tx_valid is 0, the scheduler SHALL grant round-robin starting from index (last_grant+1) mod NREQ, capture that requester's slice into tx_msg, pulse its ack bit, store the grant index, and go to LAUNCH.
REQ-016 IDLE: if req is nonzero but tx_valid is 1 (a foreign or stale frame), the scheduler SHALL not grant and SHALL stay in IDLE.
REQ-017 LAUNCH: tx_send SHALL be 1 for exactly this cycle, the start-timeout counter SHALL be cleared, and the FSM SHALL go to WAIT_START.
REQ-018 WAIT_START: on tx_valid=1, go to WAIT_DONE; otherwise increment the counter.
REQ-019 WAIT_START timeout: when the counter reaches START_TIMEOUT without tx_valid, pulse err and return to IDLE; no done pulse is issued and the grant pointer is still advanced.
REQ-020 WAIT_DONE: on tx_valid=0, pulse done[grant] and go to COOLDOWN.
REQ-021 COOLDOWN SHALL last exactly one cycle and then go to IDLE, which guarantees at least one idle clock between frames.
REQ-022 Latency: a request arriving in IDLE with tx_valid=0 SHALL produce ack in the same cycle (registered, visible the next edge) and tx_send exactly one cycle after ack.
REQ-023 The round-robin pointer last_grant SHALL update only on grant; a requester that drops req before being granted is simply skipped.
REQ-024 Changes to req or req_msg after capture SHALL not affect tx_msg.
REQ-025 A requester SHALL be granted again only after all other active requesters have been served once (fairness).
REQ-026 If tx_valid falls in the same cycle it rises in WAIT_START (a one-cycle frame), the scheduler SHALL go to WAIT_DONE and complete on the next cycle where tx_valid=0.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst=0: state=IDLE, last_grant=NREQ-1 (so requester 0 wins first), counter=0, tx_msg=0, and ack, done, tx_send, busy and err all 0.
REQ-029 Reset asserted mid-frame SHALL abort immediately with no done or err pulse; the transmitter is reset by the same signal.

Structure
REQ-030 A shared package SHALL hold the state enumeration, the payload width (5) and the default NREQ/START_TIMEOUT constants.
REQ-031 Grant selection SHALL be a sub-module rr_arbiter (inputs req and last_grant; outputs a one-hot grant and its index; purely combinational).

Verification
REQ-032 After reset, req=4'b0001, msg0=5'h15, and a transmitter model driving tx_valid high for 10 cycles starting 1 cycle after tx_send -> ack=0001, tx_send one cycle later, tx_msg=5'h15, then done=0001 after tx_valid falls, and busy back to 0 two cycles later.
REQ-033 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with exactly one frame in flight at a time.
REQ-034 tx_valid never rises after tx_send -> err pulses exactly START_TIMEOUT+1 cycles after tx_send, with no done; the next grant goes to the following index.
REQ-035 req_msg changed during WAIT_DONE -> tx_msg remains the captured value.
REQ-036 rst pulled low in WAIT_DONE -> all outputs 0 immediately; after release, requester 0 wins first.
REQ-037 tx_valid=1 while in IDLE with req pending -> no ack until tx_valid=0.
